key_entry_ctrl: RTL and testbench

Key-entry sequencer for the alarm clock. It sits between the keypad decoder and keyreg. It turns decoded key events into keyreg shift strobes and counts the entered digits. It issues single-cycle load commands to the alarm and time registers, and returns the display to current time on inactivity timeout.

---
 rtl/key_entry_ctrl.sv | 172 +++++++++++++++++
 tb/tb_key_entry_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/key_entry_ctrl.sv
// Key-entry sequencer for the alarm clock: keypad events -> keyreg shifts, alarm/time loads, inactivity timeout.
// Optional buffer range check before a load is enabled with `define DIGIT_RANGE_CHECK_EN.
module key_entry_ctrl #(
  parameter int TIMEOUT_SEC = 10,
  parameter int NUM_DIGITS  = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic       key_valid,
  input  logic [3:0] key,
  input  logic [3:0] key_buffer_ms_hr,
  input  logic [3:0] key_buffer_ls_hr,
  input  logic [3:0] key_buffer_ms_min,
  input  logic [3:0] key_buffer_ls_min,
  output logic       shift,
  output logic [3:0] key_out,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       show_new_time,
  output logic       show_a,
  output logic       entry_error
);

  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_DIGITS);
  localparam logic [7:0]       TIMEOUT  = 8'(TIMEOUT_SEC);

  localparam logic [3:0] KEY_ALARM_SET  = 4'hA;
  localparam logic [3:0] KEY_TIME_SET   = 4'hB;
  localparam logic [3:0] KEY_ALARM_SHOW = 4'hC;

  typedef enum logic [1:0] {
    SHOW_TIME  = 2'd0,
    KEY_ENTRY  = 2'd1,
    SHOW_ALARM = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] digit_cnt, digit_cnt_n;
  logic [7:0]       timer, timer_n;
  logic             shift_n, load_a_n, load_c_n, error_n;
  logic [3:0]       key_out_n;
  logic             is_digit, range_ok;
  logic [7:0]       timer_inc;

  // Hours 00..23, minutes 00..59.
  function automatic logic buffer_in_range(input logic [3:0] ms_hr, input logic [3:0] ls_hr,
                                           input logic [3:0] ms_min, input logic [3:0] ls_min);
    logic hr_ok, min_ok;
    hr_ok  = (ms_hr < 4'd2) || ((ms_hr == 4'd2) && (ls_hr <= 4'd3));
    min_ok = (ms_min <= 4'd5) && (ls_min <= 4'd9);
    return hr_ok && min_ok;
  endfunction

`ifdef DIGIT_RANGE_CHECK_EN
  assign range_ok = buffer_in_range(key_buffer_ms_hr, key_buffer_ls_hr,
                                    key_buffer_ms_min, key_buffer_ls_min);
`else
  logic unused_feedback;
  assign unused_feedback = buffer_in_range(key_buffer_ms_hr, key_buffer_ls_hr,
                                           key_buffer_ms_min, key_buffer_ls_min);
  assign range_ok = 1'b1;
`endif

  assign is_digit  = (key <= 4'd9);
  assign timer_inc = (timer == 8'hFF) ? timer : timer + 8'd1;

  assign show_new_time = (state == KEY_ENTRY);
  assign show_a        = (state == SHOW_ALARM);

  always_comb begin
    state_n     = state;
    digit_cnt_n = digit_cnt;
    timer_n     = timer;
    shift_n     = 1'b0;
    key_out_n   = 4'd0;
    load_a_n    = 1'b0;
    load_c_n    = 1'b0;
    error_n     = 1'b0;
    case (state)
      SHOW_TIME: begin
        timer_n     = 8'd0;
        digit_cnt_n = '0;
        if (key_valid) begin
          if (is_digit) begin
            shift_n     = 1'b1;
            key_out_n   = key;
            digit_cnt_n = CNT_W'(1);
            state_n     = KEY_ENTRY;
          end else if (key == KEY_ALARM_SHOW) begin
            state_n = SHOW_ALARM;
          end
        end
      end
      KEY_ENTRY: begin
        if (key_valid) begin
          if (is_digit) begin
            timer_n = 8'd0;
            if (digit_cnt < CNT_FULL) begin
              shift_n     = 1'b1;
              key_out_n   = key;
              digit_cnt_n = digit_cnt + CNT_W'(1);
            end
          end else if ((key == KEY_ALARM_SET) || (key == KEY_TIME_SET)) begin
            timer_n = 8'd0;
            if (digit_cnt == CNT_FULL) begin
              state_n     = SHOW_TIME;
              digit_cnt_n = '0;
              if (range_ok) begin
                load_a_n = (key == KEY_ALARM_SET);
                load_c_n = (key == KEY_TIME_SET);
              end else begin
                error_n = 1'b1;
              end
            end
          end
        end else if (one_second) begin
          if (timer_inc >= TIMEOUT) begin
            state_n     = SHOW_TIME;
            digit_cnt_n = '0;
            timer_n     = 8'd0;
          end else begin
            timer_n = timer_inc;
          end
        end
      end
      SHOW_ALARM: begin
        // Any key only dismisses the alarm view; it is not acted on.
        if (key_valid) begin
          state_n = SHOW_TIME;
          timer_n = 8'd0;
        end else if (one_second) begin
          if (timer_inc >= TIMEOUT) begin
            state_n = SHOW_TIME;
            timer_n = 8'd0;
          end else begin
            timer_n = timer_inc;
          end
        end
      end
      default: begin
        state_n     = SHOW_TIME;
        digit_cnt_n = '0;
        timer_n     = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= SHOW_TIME;
      digit_cnt   <= '0;
      timer       <= 8'd0;
      shift       <= 1'b0;
      key_out     <= 4'd0;
      load_new_a  <= 1'b0;
      load_new_c  <= 1'b0;
      entry_error <= 1'b0;
    end else begin
      state       <= state_n;
      digit_cnt   <= digit_cnt_n;
      timer       <= timer_n;
      shift       <= shift_n;
      key_out     <= key_out_n;
      load_new_a  <= load_a_n;
      load_new_c  <= load_c_n;
      entry_error <= error_n;
    end
  end

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Directed self-checking bench for key_entry_ctrl (TIMEOUT_SEC=10, NUM_DIGITS=4).
module tb_key_entry_ctrl;

  logic       clock = 1'b0;
  logic       reset, one_second, key_valid;
  logic [3:0] key;
  logic [3:0] fb_ms_hr, fb_ls_hr, fb_ms_min, fb_ls_min;
  logic       shift, load_new_a, load_new_c, show_new_time, show_a, entry_error;
  logic [3:0] key_out;

  int n_cmp = 0;
  int n_err = 0;

  key_entry_ctrl #(.TIMEOUT_SEC(10), .NUM_DIGITS(4)) dut (
    .clock(clock), .reset(reset), .one_second(one_second),
    .key_valid(key_valid), .key(key),
    .key_buffer_ms_hr(fb_ms_hr), .key_buffer_ls_hr(fb_ls_hr),
    .key_buffer_ms_min(fb_ms_min), .key_buffer_ls_min(fb_ls_min),
    .shift(shift), .key_out(key_out), .load_new_a(load_new_a), .load_new_c(load_new_c),
    .show_new_time(show_new_time), .show_a(show_a), .entry_error(entry_error)
  );

  always #5 clock = ~clock;

  // Apply one cycle of inputs, then settle just after the active edge.
  task automatic cyc(input logic kv, input logic [3:0] k, input logic tick);
    @(negedge clock);
    key_valid  = kv;
    key        = k;
    one_second = tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected pulse pattern: {shift, key_out, load_new_a, load_new_c, show_new_time, show_a, entry_error}
  task automatic chk_all(input string tag, input logic s, input logic [3:0] ko, input logic la,
                         input logic lc, input logic snt, input logic sa, input logic ee);
    chk(tag, {22'd0, shift, key_out, load_new_a, load_new_c, show_new_time, show_a, entry_error},
             {22'd0, s, ko, la, lc, snt, sa, ee});
  endtask

  initial begin
    reset = 1'b1; one_second = 1'b0; key_valid = 1'b0; key = 4'd0;
    fb_ms_hr = 4'd0; fb_ls_hr = 4'd0; fb_ms_min = 4'd0; fb_ls_min = 4'd0;
    cyc(0, 4'd0, 0);
    cyc(0, 4'd0, 0);
    chk_all("reset_state", 0, 4'd0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Entry 1,2,3,0 on consecutive cycles, then TIME_SET.
    cyc(1, 4'd1, 0); chk_all("digit1", 1, 4'd1, 0, 0, 1, 0, 0);
    cyc(1, 4'd2, 0); chk_all("digit2", 1, 4'd2, 0, 0, 1, 0, 0);
    cyc(1, 4'd3, 0); chk_all("digit3", 1, 4'd3, 0, 0, 1, 0, 0);
    cyc(1, 4'd0, 0); chk_all("digit0", 1, 4'd0, 0, 0, 1, 0, 0);
    cyc(0, 4'd0, 0); chk_all("idle_after_digits", 0, 4'd0, 0, 0, 1, 0, 0);
    cyc(1, 4'hB, 0); chk_all("time_set_load", 0, 4'd0, 0, 1, 0, 0, 0);
    cyc(0, 4'd0, 0); chk_all("load_c_one_cycle", 0, 4'd0, 0, 0, 0, 0, 0);

    // SET keys in SHOW_TIME are ignored.
    cyc(1, 4'hA, 0); chk_all("alarm_set_idle_ignored", 0, 4'd0, 0, 0, 0, 0, 0);
    cyc(1, 4'hE, 0); chk_all("other_code_ignored", 0, 4'd0, 0, 0, 0, 0, 0);

    // Short entry rejected, then completed; fifth digit dropped.
    cyc(1, 4'd0, 0); chk_all("a_digit0", 1, 4'd0, 0, 0, 1, 0, 0);
    cyc(1, 4'd7, 0); chk_all("a_digit7", 1, 4'd7, 0, 0, 1, 0, 0);
    cyc(1, 4'hA, 0); chk_all("alarm_set_short", 0, 4'd0, 0, 0, 1, 0, 0);
    cyc(1, 4'hB, 0); chk_all("time_set_short", 0, 4'd0, 0, 0, 1, 0, 0);
    cyc(1, 4'hC, 0); chk_all("alarm_show_in_entry", 0, 4'd0, 0, 0, 1, 0, 0);
    cyc(1, 4'd4, 0); chk_all("a_digit4", 1, 4'd4, 0, 0, 1, 0, 0);
    cyc(1, 4'd5, 0); chk_all("a_digit5", 1, 4'd5, 0, 0, 1, 0, 0);
    cyc(1, 4'd8, 0); chk_all("fifth_digit_no_shift", 0, 4'd0, 0, 0, 1, 0, 0);
    cyc(1, 4'hA, 0); chk_all("alarm_set_load", 0, 4'd0, 1, 0, 0, 0, 0);
    cyc(0, 4'd0, 0); chk_all("load_a_one_cycle", 0, 4'd0, 0, 0, 0, 0, 0);

    // Entry timeout at the 10th tick.
    cyc(1, 4'd9, 0); chk_all("t_digit9", 1, 4'd9, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 9; i++) cyc(0, 4'd0, 1);
    chk_all("entry_after_9_ticks", 0, 4'd0, 0, 0, 1, 0, 0);
    cyc(0, 4'd0, 1); chk_all("entry_timeout_10", 0, 4'd0, 0, 0, 0, 0, 0);
    cyc(1, 4'hB, 0); chk_all("no_load_after_timeout", 0, 4'd0, 0, 0, 0, 0, 0);

    // Alarm view: dismissed by a key, and by timeout.
    cyc(1, 4'hC, 0); chk_all("alarm_show", 0, 4'd0, 0, 0, 0, 1, 0);
    cyc(1, 4'd3, 0); chk_all("alarm_dismiss_key", 0, 4'd0, 0, 0, 0, 0, 0);
    cyc(1, 4'hC, 0); chk_all("alarm_show_again", 0, 4'd0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 9; i++) cyc(0, 4'd0, 1);
    chk_all("alarm_after_9_ticks", 0, 4'd0, 0, 0, 0, 1, 0);
    cyc(0, 4'd0, 1); chk_all("alarm_timeout_10", 0, 4'd0, 0, 0, 0, 0, 0);

    // Key coincident with a tick clears the timer.
    cyc(1, 4'd5, 0); chk_all("c_digit5", 1, 4'd5, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 8; i++) cyc(0, 4'd0, 1);
    cyc(1, 4'd6, 1); chk_all("key_with_tick", 1, 4'd6, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 9; i++) cyc(0, 4'd0, 1);
    chk_all("timer_cleared_by_key", 0, 4'd0, 0, 0, 1, 0, 0);
    cyc(0, 4'd0, 1); chk_all("timeout_after_clear", 0, 4'd0, 0, 0, 0, 0, 0);

    // Reset mid-entry discards everything.
    cyc(1, 4'd1, 0);
    cyc(1, 4'd2, 0);
    cyc(1, 4'd3, 0);
    cyc(1, 4'd4, 0); chk_all("r_digit4", 1, 4'd4, 0, 0, 1, 0, 0);
    reset = 1'b1;
    cyc(1, 4'hB, 0); chk_all("reset_mid_entry", 0, 4'd0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    cyc(1, 4'hB, 0); chk_all("no_load_after_reset", 0, 4'd0, 0, 0, 0, 0, 0);

    // Feedback buffer: out-of-range hours 25:00, then valid 23:59.
    fb_ms_hr = 4'd2; fb_ls_hr = 4'd5; fb_ms_min = 4'd0; fb_ls_min = 4'd0;
    cyc(1, 4'd2, 0); cyc(1, 4'd5, 0); cyc(1, 4'd0, 0); cyc(1, 4'd0, 0);
    cyc(1, 4'hB, 0);
`ifdef DIGIT_RANGE_CHECK_EN
    chk_all("range_25_00_error", 0, 4'd0, 0, 0, 0, 0, 1);
`else
    chk_all("range_ignored_load", 0, 4'd0, 0, 1, 0, 0, 0);
`endif
    cyc(0, 4'd0, 0); chk_all("after_range_25", 0, 4'd0, 0, 0, 0, 0, 0);
    fb_ms_hr = 4'd2; fb_ls_hr = 4'd3; fb_ms_min = 4'd5; fb_ls_min = 4'd9;
    cyc(1, 4'd2, 0); cyc(1, 4'd3, 0); cyc(1, 4'd5, 0); cyc(1, 4'd9, 0);
    cyc(1, 4'hB, 0); chk_all("range_23_59_load", 0, 4'd0, 0, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
